// File: rtl/vga_timing.sv
// VGA raster timing source: free-running pixel/line counters with registered sync and blanking decode.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output used by animation stages.
module vga_timing #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic        frame_start,
  output logic [15:0] frame_cnt
`else
  output logic        frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // 12-bit constants so a 2048-wide sync end never overflows the compare
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_BLANK = 12'(H_VISIBLE);
  localparam logic [11:0] HS_BEG  = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_BLANK = 12'(V_VISIBLE);
  localparam logic [11:0] VS_BEG  = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_VISIBLE + V_FP + V_SYNC);

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_timing: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_total_chk
    $error("vga_timing: V_TOTAL exceeds 2048");
  end

  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_wrap;
  logic        hblnk_nxt;
  logic        hsync_nxt;
  logic        vblnk_nxt;
  logic        vsync_nxt;
  logic        fs_nxt;

  // Decode is taken from the next counter values so every registered output lines up with hcount/vcount
  always_comb begin
    h_wrap = ({1'b0, hcount} == H_LAST);
    h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
    v_nxt  = vcount;
    if (h_wrap) begin
      v_nxt = ({1'b0, vcount} == V_LAST) ? 11'd0 : vcount + 11'd1;
    end
    hblnk_nxt = ({1'b0, h_nxt} >= H_BLANK);
    vblnk_nxt = ({1'b0, v_nxt} >= V_BLANK);
    hsync_nxt = (({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_nxt = (({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    fs_nxt    = (h_nxt == 11'd0) && (v_nxt == 11'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (fs_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two small-geometry instances (positive polarity, and negative polarity with
// zero-width porches) checked every cycle against an arithmetic model of time since reset.
module tb_vga_timing;

  // Instance A: positive polarity, all porches non-zero (32 x 16 -> 512 clocks per frame)
  localparam int A_HV = 20, A_HFP = 3, A_HS = 5, A_HBP = 4;
  localparam int A_VV = 10, A_VFP = 1, A_VS = 2, A_VBP = 3;
  // Instance B: negative polarity, H_FP and V_BP zero (17 x 9 -> 153 clocks per frame)
  localparam int B_HV = 12, B_HFP = 0, B_HS = 3, B_HBP = 2;
  localparam int B_VV = 6,  B_VFP = 2, B_VS = 1, B_VBP = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount;
  logic        a_hsync, a_hblnk, a_vsync, a_vblnk, a_fs;
  logic        b_hsync, b_hblnk, b_vsync, b_vblnk, b_fs;
  logic [15:0] a_fc, b_fc;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  bit in_rst  = 1'b1;

  always #5 clk = ~clk;

  vga_timing #(
    .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .hcount(a_hcount), .hsync(a_hsync), .hblnk(a_hblnk),
    .vcount(a_vcount), .vsync(a_vsync), .vblnk(a_vblnk),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(a_fs), .frame_cnt(a_fc)
`else
    .frame_start(a_fs)
`endif
  );

  vga_timing #(
    .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .hcount(b_hcount), .hsync(b_hsync), .hblnk(b_hblnk),
    .vcount(b_vcount), .vsync(b_vsync), .vblnk(b_vblnk),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(b_fs), .frame_cnt(b_fc)
`else
    .frame_start(b_fs)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign a_fc = 16'd0;
  assign b_fc = 16'd0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d rst=%0d got=%0d exp=%0d", tag, t, in_rst, got, exp);
    end
  endtask

  // Expected outputs come straight from elapsed clocks since reset release
  task automatic check_dut(input string id,
                           input int hv, input int hfp, input int hsw, input int hbp,
                           input int vv, input int vfp, input int vsw, input int vbp,
                           input bit hpol, input bit vpol,
                           input logic [10:0] hc, input logic [10:0] vc,
                           input logic hs, input logic hb, input logic vs, input logic vb,
                           input logic fs, input logic [15:0] fc);
    int ht, vt, eh, ev, efc;
    bit ehb, evb, ehs, evs, efs;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (in_rst) begin
      eh = 0; ev = 0; ehb = 0; evb = 0; efs = 0; efc = 0;
      ehs = !hpol; evs = !vpol;
    end else begin
      eh  = t % ht;
      ev  = (t / ht) % vt;
      ehb = (eh >= hv);
      evb = (ev >= vv);
      ehs = (eh >= hv + hfp && eh < hv + hfp + hsw) ? hpol : !hpol;
      evs = (ev >= vv + vfp && ev < vv + vfp + vsw) ? vpol : !vpol;
      efs = (eh == 0 && ev == 0);
      efc = (t / (ht * vt)) % 65536;
    end
    check_val({id, ".hcount"}, 32'(hc), 32'(eh));
    check_val({id, ".vcount"}, 32'(vc), 32'(ev));
    check_val({id, ".hblnk"}, 32'(hb), 32'(ehb));
    check_val({id, ".vblnk"}, 32'(vb), 32'(evb));
    check_val({id, ".hsync"}, 32'(hs), 32'(ehs));
    check_val({id, ".vsync"}, 32'(vs), 32'(evs));
    check_val({id, ".frame_start"}, 32'(fs), 32'(efs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_val({id, ".frame_cnt"}, 32'(fc), 32'(efc));
`else
    if (fc !== 16'd0) check_val({id, ".frame_cnt_tie"}, 32'(fc), 32'd0);
`endif
  endtask

  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    if (r) begin
      t = 0;
      in_rst = 1'b1;
    end else begin
      t++;
      in_rst = 1'b0;
    end
    #1;
    check_dut("A", A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP, 1'b1, 1'b1,
              a_hcount, a_vcount, a_hsync, a_hblnk, a_vsync, a_vblnk, a_fs, a_fc);
    check_dut("B", B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP, 1'b0, 1'b0,
              b_hcount, b_vcount, b_hsync, b_hblnk, b_vsync, b_vblnk, b_fs, b_fc);
  endtask

  initial begin
    // Reset held for three cycles, then three full frames of A plus a few lines
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 3 * 512 + 40; i++) step(1'b0);

    // Random run lengths separated by short reset pulses landing mid-line/mid-frame
    for (int seg = 0; seg < 12; seg++) begin
      int run_len, rst_len;
      run_len = int'($urandom_range(1, 700));
      rst_len = int'($urandom_range(1, 3));
      for (int i = 0; i < rst_len; i++) step(1'b1);
      for (int i = 0; i < run_len; i++) step(1'b0);
    end

    // Single-cycle reset mid-frame, then run past a frame wrap
    for (int i = 0; i < 300; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 600; i++) step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
